rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter for 8 requesters that produces the one-hot 8-bit `grant` vector feeding the 8-to-3 encoder directly downstream.
- The encoder's `d` is driven from `grant` and its `enable` from `grant_valid`.
- Guarantees at most one bit set, so the encoder never sees a multi-hot input.
- Grants are held while the owner keeps requesting; ownership rotates fairly.

Parameters:
- N, 8, number of requesters; fixed at 8 to match the encoder width, other values unsupported.
- HOLD_MAX, 16, maximum consecutive grant cycles per owner; used only with ARB_HOLD_TIMEOUT_EN, legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- enable  input  1  arbitration enable; low forbids new grants and forces release
- req  input  8  request vector, bit i = requester i, level-sensitive
- grant  output  8  registered one-hot grant, 0 when idle
- grant_valid  output  1  registered, high iff grant is non-zero
- timeout  output  1  registered 1-cycle pulse on forced release (see Optional Feature)

Behaviour:
- Reset (reset_n low at a rising edge, takes priority over everything):
  - grant=0, grant_valid=0, timeout=0.
  - Priority pointer ptr=0; state IDLE; hold counter=0.
  - Reset asserted mid-grant clears the grant at that edge.
- Selection function (combinational): first set bit of req searched ascending from ptr, wrapping 7->0.
  - Example: ptr=5, req=8'b0010_0110 selects bit 5; ptr=6 with the same req selects bit 1.
- State IDLE:
  - If enable=1 and req!=0: at the next edge grant<=onehot(sel), grant_valid<=1, go to GRANT. Latency is 1 cycle from req sampled to grant visible.
  - Otherwise stay in IDLE with outputs 0.
- State GRANT, owner g:
  - Hold: enable=1 and req[g]=1 -> grant unchanged.
  - Release: req[g]=0 or enable=0.
    - ptr<=(g+1) mod 8.
    - If enable=1 and another request exists, evaluate selection with the new pointer value and hand over at the same edge (zero bubble); stay in GRANT.
    - Otherwise grant<=0, grant_valid<=0, go to IDLE.
- Simultaneous events:
  - req[g] dropping while other bits rise is a handover; the new bits are eligible.
  - enable low overrides all requests: release at the edge, no new grant until enable returns high. Pointer still advances.
- ptr updates only on release, never on a new grant from IDLE.
- Invariants:
  - grant is always 0 or one-hot.
  - grant_valid == (grant != 0) every cycle.
  - grant bit only ever set for a bit with req high at the selecting edge.
- Starvation-free: every persistent requester is granted within 7 handovers.

Optional Feature:
- Macro ARB_HOLD_TIMEOUT_EN.
- Defined:
  - Hold counter clears at each new grant and increments each cycle in GRANT.
  - When the owner has held grant_valid for HOLD_MAX consecutive cycles, the next edge performs a forced release exactly as if req[g]=0, including handover.
  - If g is the only requester it is re-granted immediately and the counter restarts.
  - timeout=1 for the single cycle following a forced release, otherwise 0.
- Undefined: no counter logic; grants are unbounded; timeout tied to 0.

Test Plan:
- Reset/idle: reset_n=0 for 2 cycles with req=8'hFF -> grant=0, grant_valid=0, timeout=0. After release with enable=1, grant=8'h01 one cycle later.
- Sweep, each step 3 cycles: req=(1<<i) for i=0..7 with enable=1 -> grant=(1<<i) one cycle after each req change, grant_valid=1. Encoder y reads i; y monitored 0..7.
- Round-robin: req=8'h81 held.
  - First grant is 8'h01.
  - Drop bit 0 for one cycle -> handover to 8'h80 with no bubble.
  - Re-raise bit 0 and drop bit 7 -> wraps to 8'h01.
- Pointer rotation: ptr=3 after a bit-2 release, req=8'b0010_0110 -> grant=8'h20 (bit 5), not bit 1 or 2.
- Enable/reset mid-grant:
  - enable=0 while grant=8'h04 -> grant=0 at the next edge, no grant while enable=0 even with req=8'hFF.
  - reset_n=0 mid-grant -> all outputs 0 and ptr=0.
- Timeout (ARB_HOLD_TIMEOUT_EN, HOLD_MAX=4):
  - req=8'h03 held -> bit 0 granted exactly 4 cycles, then grant=8'h02 with timeout=1 for one cycle.
  - req=8'h01 alone -> re-granted immediately after 4 cycles, timeout pulses.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters driving a one-hot grant into an 8-to-3 encoder.
// Optional hold timeout enabled by defining ARB_HOLD_TIMEOUT_EN.
module rr_grant_arbiter #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (N != 8 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_param_check
    $error("rr_grant_arbiter: N must be 8 and HOLD_MAX must be 2..255");
  end

  state_t         state_q;
  logic [2:0]     ptr_q;
  logic [2:0]     owner_q;
  logic [N-1:0]   grant_q;
  logic           grant_valid_q;
  logic           timeout_q;

  logic [2:0]     selPtr;
  logic [2:0]     selIdx;
  logic           anyReq;
  logic           ownerHolds;
  logic           forcedRelease;
  logic           releaseNow;

  // First set request bit searched ascending from p, wrapping 7 -> 0.
  function automatic logic [2:0] pickFrom(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    pickFrom = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) pickFrom = idx;
    end
  endfunction

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0] holdCnt_q;
  assign forcedRelease = ownerHolds && (holdCnt_q == 8'(HOLD_MAX - 1));
`else
  assign forcedRelease = 1'b0;
`endif

  // On a release the handover search starts just past the outgoing owner.
  always_comb begin
    selPtr     = (state_q == GRANT) ? (owner_q + 3'd1) : ptr_q;
    selIdx     = pickFrom(req, selPtr);
    anyReq     = |req;
    ownerHolds = enable && req[owner_q];
    releaseNow = !ownerHolds || forcedRelease;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= 3'd0;
      owner_q       <= 3'd0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      holdCnt_q     <= 8'd0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && anyReq) begin
            owner_q       <= selIdx;
            grant_q       <= N'(1) << selIdx;
            grant_valid_q <= 1'b1;
            state_q       <= GRANT;
`ifdef ARB_HOLD_TIMEOUT_EN
            holdCnt_q     <= 8'd0;
`endif
          end else begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (releaseNow) begin
            ptr_q     <= owner_q + 3'd1;
            timeout_q <= forcedRelease;
            if (enable && anyReq) begin
              owner_q       <= selIdx;
              grant_q       <= N'(1) << selIdx;
              grant_valid_q <= 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
              holdCnt_q     <= 8'd0;
`endif
            end else begin
              grant_q       <= '0;
              grant_valid_q <= 1'b0;
              state_q       <= IDLE;
            end
          end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
            holdCnt_q <= holdCnt_q + 8'd1;
`endif
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_q       <= '0;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
`ifdef ARB_HOLD_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed self-checking bench for rr_grant_arbiter in its default build
// (ARB_HOLD_TIMEOUT_EN undefined, so timeout must stay 0).
module tb_rr_grant_arbiter;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_grant_arbiter #(.N(8), .HOLD_MAX(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs away from the rising edge, then wait so one edge has consumed them.
  task automatic applyStimulus(input logic rn, input logic en, input logic [7:0] r);
    reset_n = rn;
    enable  = en;
    req     = r;
    @(negedge clk);
  endtask

  task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expGrant, input logic expValid);
    compare({tag, ".grant"}, grant, expGrant);
    compare({tag, ".valid"}, {7'd0, grant_valid}, {7'd0, expValid});
    compare({tag, ".timeout"}, {7'd0, timeout}, 8'h00);
  endtask

  // Downstream 8-to-3 encoder as seen by the consumer of grant.
  function automatic logic [7:0] encodeY(input logic [7:0] g);
    encodeY = 8'hFF;
    for (int b = 0; b < 8; b++) if (g[b]) encodeY = 8'(b);
  endfunction

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    req     = 8'hFF;

    applyStimulus(1'b0, 1'b1, 8'hFF);
    checkOutput("reset1", 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    checkOutput("reset2", 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    checkOutput("firstGrant", 8'h01, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    checkOutput("hold0", 8'h01, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h00);
    checkOutput("idleAfterDrop", 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h01 << i);
      checkOutput($sformatf("sweep%0d.first", i), 8'h01 << i, 1'b1);
      applyStimulus(1'b1, 1'b1, 8'h01 << i);
      applyStimulus(1'b1, 1'b1, 8'h01 << i);
      checkOutput($sformatf("sweep%0d.held", i), 8'h01 << i, 1'b1);
      compare($sformatf("sweep%0d.encY", i), encodeY(grant), 8'(i));
    end

    applyStimulus(1'b1, 1'b1, 8'h00);
    checkOutput("sweepEnd", 8'h00, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h81);
    checkOutput("rr.first", 8'h01, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h80);
    checkOutput("rr.handover", 8'h80, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h81);
    checkOutput("rr.hold7", 8'h80, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h01);
    checkOutput("rr.wrap", 8'h01, 1'b1);

    applyStimulus(1'b1, 1'b1, 8'h04);
    checkOutput("ptr.grant2", 8'h04, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h22);
    checkOutput("ptr.after2", 8'h20, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h00);
    checkOutput("ptr.idle", 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h26);
    checkOutput("ptr.from6", 8'h02, 1'b1);

    applyStimulus(1'b1, 1'b1, 8'h04);
    checkOutput("en.grant2", 8'h04, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("en.release", 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("en.blocked", 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    checkOutput("en.resume", 8'h08, 1'b1);

    applyStimulus(1'b0, 1'b1, 8'hFF);
    checkOutput("rst.midGrant", 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    checkOutput("rst.ptrZero", 8'h01, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hFE);
    checkOutput("rst.next", 8'h02, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
